// File: rtl/mips150_lsu.sv
// MIPS150 load/store unit: handshaked, multi-cycle path from the X-stage address to DMEM/IMEM/IO.
// Define LSU_ERR_STICKY_EN to add sticky first-error capture (err_clr, err_sticky, err_addr).
module mips150_lsu #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MEM_AW   = 12,
   parameter logic [3:0]  DMEM_TAG = 4'h1,
   parameter logic [3:0]  IMEM_TAG = 4'h2,
   parameter logic [3:0]  IO_TAG   = 4'h8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_uns,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [4:0]          req_rd,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [1:0]          mem_sel,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                resp_valid,
   output logic [4:0]          resp_rd,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_err
`ifdef LSU_ERR_STICKY_EN
  ,input  logic                err_clr,
   output logic                err_sticky,
   output logic [31:0]         err_addr
`endif
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(LANES);
   localparam int unsigned WA_W  = MEM_AW + OFF_W;

   typedef enum logic [1:0] {StIdle, StCmd, StRdWait, StResp} lsuState_t;
   lsuState_t stateQ, stateD;

   logic              weQ, unsQ, respErrQ;
   logic [1:0]        sizeQ, selQ;
   logic [WA_W-1:0]   addrQ;
   logic [DATA_W-1:0] wdataQ, respDataQ;
   logic [4:0]        rdQ;

   logic              accept, reqErr, misaligned, unmapped;
   logic [1:0]        reqSel;
   int unsigned       nBytes, byteOff;
   logic [LANES-1:0]  storeEn;
   logic [DATA_W-1:0] storeData, shifted, field, fill, loadExt;
   logic              unusedAddr;

   assign unusedAddr = ^req_addr[27:WA_W];
   assign accept     = (stateQ == StIdle) && req_valid;

   always_comb begin
      reqSel   = 2'b00;
      unmapped = 1'b0;
      if (req_addr[31:28] == DMEM_TAG)      reqSel = 2'b00;
      else if (req_addr[31:28] == IMEM_TAG) reqSel = 2'b01;
      else if (req_addr[31:28] == IO_TAG)   reqSel = 2'b10;
      else                                  unmapped = 1'b1;
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
      reqErr = misaligned | unmapped | (!req_we && reqSel == 2'b01)
             | (req_size == 2'b11 && DATA_W < 64);
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:   if (req_valid) stateD = reqErr ? StResp : StCmd;
         StCmd:    if (mem_ready) stateD = weQ ? StIdle : StRdWait;
         StRdWait: if (mem_rvalid) stateD = StResp;
         StResp:   stateD = StIdle;
         default:  stateD = StIdle;
      endcase
   end

   // Lane i (from LSB) holds byte address LANES-1-i; store data repeats every nBytes lanes.
   always_comb begin
      nBytes  = 32'd1 << sizeQ;
      byteOff = 32'(addrQ[OFF_W-1:0]);
      for (int unsigned i = 0; i < LANES; i++) begin
         storeEn[i]          = (i + byteOff + nBytes >= LANES) && (i + byteOff < LANES);
         storeData[8*i +: 8] = wdataQ[8*(i % nBytes) +: 8];
      end
      shifted = mem_rdata << (8 * byteOff);
      field   = shifted >> (DATA_W - 8 * nBytes);
      fill    = {DATA_W{1'b1}} << (8 * nBytes);
      loadExt = (!unsQ && shifted[DATA_W-1]) ? (field | fill) : field;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         weQ       <= 1'b0;
         unsQ      <= 1'b0;
         sizeQ     <= 2'b00;
         selQ      <= 2'b00;
         addrQ     <= '0;
         wdataQ    <= '0;
         rdQ       <= '0;
         respDataQ <= '0;
         respErrQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            weQ       <= req_we;
            unsQ      <= req_uns;
            sizeQ     <= req_size;
            selQ      <= reqSel;
            addrQ     <= req_addr[WA_W-1:0];
            wdataQ    <= req_wdata;
            rdQ       <= req_rd;
            respErrQ  <= reqErr;
            respDataQ <= '0;
         end else if (stateQ == StRdWait && mem_rvalid) begin
            respDataQ <= loadExt;
         end
      end
   end

   assign req_ready  = (stateQ == StIdle);
   assign mem_valid  = (stateQ == StCmd);
   assign mem_sel    = selQ;
   assign mem_addr   = addrQ[WA_W-1:OFF_W];
   assign mem_wdata  = storeData;
   assign mem_we     = (mem_valid && weQ) ? storeEn : '0;
   assign resp_valid = (stateQ == StResp);
   assign resp_rd    = rdQ;
   assign resp_data  = respDataQ;
   assign resp_err   = respErrQ;

`ifdef LSU_ERR_STICKY_EN
   // Clear wins over a simultaneous new error; only the first error address is kept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sticky <= 1'b0;
         err_addr   <= '0;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
         err_addr   <= '0;
      end else if (accept && reqErr && !err_sticky) begin
         err_sticky <= 1'b1;
         err_addr   <= req_addr;
      end
   end
`else
   // Errors are visible only through resp_err.
`endif

endmodule
